// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transaction scheduler
package spi_pkg;

  localparam int SEL_W      = 2;
  localparam int DATA_W     = 8;
  localparam int NUM_SLAVES = 3;
  localparam logic [SEL_W-1:0] SEL_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    RESP
  } state_t;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel != SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// rtl/spi_cmd_fifo.sv - synchronous command FIFO feeding the scheduler FSM
module spi_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  // full/empty come straight from the level register, so ready never sees pop combinationally
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_next = level;
    case ({do_push, do_pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// rtl/spi_txn_scheduler.sv - queues SPI commands and runs them one at a time through spi_top
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TO    = 16,
  parameter int DONE_TO    = 1024,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              rsp_err,
  output logic              spi_start,
  output logic [SEL_W-1:0]  spi_slaveselect,
  output logic [DATA_W-1:0] spi_master_data,
  input  logic [DATA_W-1:0] spi_master_rx,
  input  logic              spi_done,
  output logic              busy,
  output logic [LW-1:0]     fifo_level
);

  localparam int TW = $clog2(DONE_TO + 1);

  state_t            state;
  state_t            state_next;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_inc;
  logic              pop;
  logic              timeout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [SEL_W+DATA_W-1:0] head;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_data;

  assign {head_sel, head_data} = head;

  spi_cmd_fifo #(
    .WIDTH(SEL_W + DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .wdata ({cmd_sel, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = state != IDLE;
  assign rsp_valid = state == RESP;
  assign timer_inc = (timer == '1) ? timer : timer + TW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    spi_start  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = sel_legal(head_sel) ? LAUNCH : RESP;
        end
      end
      LAUNCH: begin
        spi_start  = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!spi_done) begin
          state_next = WAIT_DONE;
        end else if (timer >= TW'(BUSY_TO)) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          state_next = CAPTURE;
        end else if (timer >= TW'(DONE_TO)) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      CAPTURE: state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // timer counts cycles since the start pulse, then since done fell
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer           <= '0;
      rsp_data        <= '0;
      rsp_sel         <= '0;
      rsp_err         <= 1'b0;
      spi_slaveselect <= '0;
      spi_master_data <= '0;
    end else begin
      if (pop) begin
        rsp_sel  <= head_sel;
        rsp_data <= '0;
        rsp_err  <= !sel_legal(head_sel);
        if (sel_legal(head_sel)) begin
          spi_slaveselect <= head_sel;
          spi_master_data <= head_data;
        end
      end
      case (state)
        LAUNCH:    timer <= TW'(1);
        WAIT_BUSY: timer <= spi_done ? timer_inc : TW'(1);
        WAIT_DONE: timer <= timer_inc;
        default:   timer <= timer;
      endcase
      if (timeout) rsp_err <= 1'b1;
      // rx is sampled a cycle after done rises so the shift register has settled
      if (state == CAPTURE) rsp_data <= spi_master_rx;
    end
  end

endmodule
